// File: rtl/hrav_axil_regbank.sv
// AXI4-Lite slave register bank: read/write control registers with write pulses,
// read-only status registers, SLVERR for status writes and unmapped addresses.
module hrav_axil_regbank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_CTRL   = 8,
   parameter int NUM_STAT   = 8,
   parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_DEFAULT = '0,
   localparam int NS = (NUM_STAT > 0) ? NUM_STAT : 1
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   input  logic                           AWVALID,
   output logic                           AWREADY,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   input  logic [DATA_WIDTH/8-1:0]        WSTRB,
   input  logic                           WVALID,
   output logic                           WREADY,
   output logic [1:0]                     BRESP,
   output logic                           BVALID,
   input  logic                           BREADY,
   input  logic [ADDR_WIDTH-1:0]          ARADDR,
   input  logic                           ARVALID,
   output logic                           ARREADY,
   output logic [DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                     RRESP,
   output logic                           RVALID,
   input  logic                           RREADY,
   output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
   output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
   input  logic [NS*DATA_WIDTH-1:0]       stat_regs,
   output logic [1:0]                     w_state_o,
   output logic                           r_state_o
);

   // Handshakes: a beat transfers on a rising edge where VALID and READY are both high;
   // VALID, once raised by this slave, holds with its payload stable until READY.

   localparam int IW = ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hDEADBEEF);

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   w_state_t w_state_q, w_state_d;
   r_state_t r_state_q, r_state_d;

   logic [ADDR_WIDTH-1:0]                awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]              wstrb_q, wstrb_d;
   logic [NUM_CTRL-1:0][DATA_WIDTH-1:0]  ctrl_q, ctrl_d;
   logic [NUM_CTRL-1:0]                  pulse_q, pulse_d;
   logic [1:0]                           bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;
   logic [1:0]                           rresp_q, rresp_d;

   logic                    commit;
   logic                    ctrl_hit;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_data;
   logic [DATA_WIDTH/8-1:0] c_strb;
   logic [IW-1:0]           c_idx;
   logic [IW-1:0]           r_idx;
   logic [DATA_WIDTH-1:0]   rd_val;
   logic [1:0]              rd_resp;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0], awaddr_q[1:0]};

   assign AWREADY       = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA);
   assign WREADY        = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR);
   assign BVALID        = (w_state_q == W_RESP);
   assign BRESP         = bresp_q;
   assign ARREADY       = (r_state_q == R_IDLE);
   assign RVALID        = (r_state_q == R_RESP);
   assign RDATA         = rdata_q;
   assign RRESP         = rresp_q;
   assign ctrl_regs     = ctrl_q;
   assign ctrl_wr_pulse = pulse_q;
   assign w_state_o     = w_state_q;
   assign r_state_o     = r_state_q;

   // Commit takes whichever half was latched earlier and the other half live off the bus.
   assign c_addr = (w_state_q == W_HAVE_ADDR) ? awaddr_q : AWADDR;
   assign c_data = (w_state_q == W_HAVE_DATA) ? wdata_q  : WDATA;
   assign c_strb = (w_state_q == W_HAVE_DATA) ? wstrb_q  : WSTRB;
   assign c_idx  = c_addr[ADDR_WIDTH-1:2];
   assign r_idx  = ARADDR[ADDR_WIDTH-1:2];

   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      commit    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (AWVALID && WVALID) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end else if (AWVALID) begin
               awaddr_d  = AWADDR;
               w_state_d = W_HAVE_ADDR;
            end else if (WVALID) begin
               wdata_d   = WDATA;
               wstrb_d   = WSTRB;
               w_state_d = W_HAVE_DATA;
            end
         end
         W_HAVE_ADDR: begin
            if (WVALID) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_HAVE_DATA: begin
            if (AWVALID) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      ctrl_d   = ctrl_q;
      pulse_d  = '0;
      bresp_d  = bresp_q;
      ctrl_hit = 1'b0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (commit && (c_idx == IW'(k))) begin
            ctrl_hit   = 1'b1;
            pulse_d[k] = 1'b1;
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
               if (c_strb[i]) ctrl_d[k][i*8 +: 8] = c_data[i*8 +: 8];
            end
         end
      end
      if (commit) bresp_d = ctrl_hit ? RESP_OKAY : RESP_SLVERR;
   end

   // Read mux sees ctrl_q, so a read on the commit edge returns the pre-write value.
   always_comb begin
      rd_val  = BAD_DATA;
      rd_resp = RESP_SLVERR;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (r_idx == IW'(k)) begin
            rd_val  = ctrl_q[k];
            rd_resp = RESP_OKAY;
         end
      end
      for (int k = 0; k < NUM_STAT; k++) begin
         if (r_idx == IW'(NUM_CTRL + k)) begin
            rd_val  = stat_regs[k*DATA_WIDTH +: DATA_WIDTH];
            rd_resp = RESP_OKAY;
         end
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ARVALID) begin
               rdata_d   = rd_val;
               rresp_d   = rd_resp;
               r_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (RREADY) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         ctrl_q    <= CTRL_DEFAULT;
         pulse_q   <= '0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         ctrl_q    <= ctrl_d;
         pulse_q   <= pulse_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

endmodule

// File: tb/tb_hrav_axil_regbank.sv
// Directed bench for hrav_axil_regbank: reset, write orderings, strobes, SLVERR,
// back-pressure stalls, read/write collision and reset mid-transaction.
module tb_hrav_axil_regbank;

   localparam logic [255:0] CTRL_DEF = {160'h0, 32'hAABBCCDD, 32'h0, 32'h1};

   logic         ACLK = 1'b0;
   logic         ARESET;
   logic [31:0]  AWADDR;
   logic         AWVALID;
   logic         AWREADY;
   logic [31:0]  WDATA;
   logic [3:0]   WSTRB;
   logic         WVALID;
   logic         WREADY;
   logic [1:0]   BRESP;
   logic         BVALID;
   logic         BREADY;
   logic [31:0]  ARADDR;
   logic         ARVALID;
   logic         ARREADY;
   logic [31:0]  RDATA;
   logic [1:0]   RRESP;
   logic         RVALID;
   logic         RREADY;
   logic [255:0] ctrl_regs;
   logic [7:0]   ctrl_wr_pulse;
   logic [255:0] stat_regs;
   logic [1:0]   w_state_o;
   logic         r_state_o;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] exp_ctrl [8];

   hrav_axil_regbank #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CTRL(8), .NUM_STAT(8), .CTRL_DEFAULT(CTRL_DEF)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_regs(stat_regs),
      .w_state_o(w_state_o), .r_state_o(r_state_o)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_bus();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      BREADY = 1'b0; RREADY = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1; AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
      idle_bus();
      for (int k = 0; k < 8; k++) begin
         exp_ctrl[k] = CTRL_DEF[k*32 +: 32];
         stat_regs[k*32 +: 32] = 32'h5100_0000 + k;
      end
      tick(); tick();
      tests_run++; if (ctrl_regs !== CTRL_DEF) begin tests_failed++; $display("FAIL reset_ctrl: got %h exp %h", ctrl_regs, CTRL_DEF); end
      tests_run++; if ({BVALID, RVALID, ctrl_wr_pulse} !== 10'h0) begin tests_failed++; $display("FAIL reset_valid_pulse: got %b/%b/%h exp 0", BVALID, RVALID, ctrl_wr_pulse); end
      tests_run++; if ({BRESP, RRESP, RDATA} !== 36'h0) begin tests_failed++; $display("FAIL reset_resp_rdata: got %b %b %h exp 0", BRESP, RRESP, RDATA); end
      tests_run++; if ({w_state_o, r_state_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_state: got %b %b exp 00 0", w_state_o, r_state_o); end
      ARESET = 1'b0;
      tick();
      tests_run++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin tests_failed++; $display("FAIL reset_ready: got %b exp 111", {AWREADY, WREADY, ARREADY}); end
   endtask

   task automatic test_read_default();
      ARADDR = 32'h0; ARVALID = 1'b1;
      tests_run++; if (ARREADY !== 1'b1) begin tests_failed++; $display("FAIL rd_arready: got %b exp 1", ARREADY); end
      tick();
      ARVALID = 1'b0;
      tests_run++; if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'h1}) begin tests_failed++; $display("FAIL rd_default: got %b %b %h exp 1 00 00000001", RVALID, RRESP, RDATA); end
      tests_run++; if (ARREADY !== 1'b0) begin tests_failed++; $display("FAIL rd_arready_busy: got %b exp 0", ARREADY); end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      tests_run++; if (RVALID !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid_drop: got %b exp 0", RVALID); end
   endtask

   task automatic test_write_same_cycle();
      AWADDR = 32'h04; WDATA = 32'hCAFE0018; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      exp_ctrl[1] = 32'hCAFE0018;
      tests_run++; if (ctrl_regs[32 +: 32] !== exp_ctrl[1]) begin tests_failed++; $display("FAIL wr_both_data: got %h exp %h", ctrl_regs[32 +: 32], exp_ctrl[1]); end
      tests_run++; if ({BVALID, BRESP} !== 3'b100) begin tests_failed++; $display("FAIL wr_both_bresp: got %b %b exp 1 00", BVALID, BRESP); end
      tests_run++; if (ctrl_wr_pulse !== 8'h02) begin tests_failed++; $display("FAIL wr_both_pulse: got %h exp 02", ctrl_wr_pulse); end
      tick();
      tests_run++; if ({BVALID, ctrl_wr_pulse} !== 9'h100) begin tests_failed++; $display("FAIL wr_both_pulse_once: got %b %h exp 1 00", BVALID, ctrl_wr_pulse); end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      tests_run++; if (BVALID !== 1'b0) begin tests_failed++; $display("FAIL wr_both_bvalid_drop: got %b exp 0", BVALID); end
   endtask

   task automatic test_w_first_strobe();
      WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
      tick();
      WVALID = 1'b0; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
      tests_run++; if ({w_state_o, AWREADY, WREADY} !== 4'b1010) begin tests_failed++; $display("FAIL wfirst_state: got %b %b %b exp 10 1 0", w_state_o, AWREADY, WREADY); end
      tick(); tick();
      AWADDR = 32'h08; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      exp_ctrl[2] = 32'hAA22CC44;
      tests_run++; if (ctrl_regs[64 +: 32] !== exp_ctrl[2]) begin tests_failed++; $display("FAIL wfirst_strobe: got %h exp %h", ctrl_regs[64 +: 32], exp_ctrl[2]); end
      tests_run++; if ({BVALID, BRESP, ctrl_wr_pulse} !== {1'b1, 2'b00, 8'h04}) begin tests_failed++; $display("FAIL wfirst_resp: got %b %b %h exp 1 00 04", BVALID, BRESP, ctrl_wr_pulse); end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
   endtask

   task automatic test_slverr();
      AWADDR = 32'h20; WDATA = 32'h12345678; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h80; ARVALID = 1'b1;
      tick();
      idle_bus();
      tests_run++; if ({BVALID, BRESP, ctrl_wr_pulse} !== {1'b1, 2'b10, 8'h00}) begin tests_failed++; $display("FAIL err_bresp: got %b %b %h exp 1 10 00", BVALID, BRESP, ctrl_wr_pulse); end
      tests_run++; if (ctrl_regs !== {exp_ctrl[7], exp_ctrl[6], exp_ctrl[5], exp_ctrl[4], exp_ctrl[3], exp_ctrl[2], exp_ctrl[1], exp_ctrl[0]}) begin tests_failed++; $display("FAIL err_no_change: got %h", ctrl_regs); end
      tests_run++; if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b10, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL err_rdata: got %b %b %h exp 1 10 deadbeef", RVALID, RRESP, RDATA); end
      BREADY = 1'b1; RREADY = 1'b1;
      tick();
      RREADY = 1'b0; BREADY = 1'b0;
      ARADDR = 32'h26; ARVALID = 1'b1;
      tick();
      ARVALID = 1'b0;
      tests_run++; if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'h51000001}) begin tests_failed++; $display("FAIL stat_read: got %b %b %h exp 1 00 51000001", RVALID, RRESP, RDATA); end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
   endtask

   task automatic test_stall();
      AWADDR = 32'h0C; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h04; ARVALID = 1'b1;
      tick();
      exp_ctrl[3] = 32'h0BADF00D;
      AWADDR = 32'h10; WDATA = 32'h99999999; ARADDR = 32'h08;
      for (int i = 0; i < 10; i++) begin
         tests_run++; if ({BVALID, BRESP, RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 1'b1, 2'b00, 32'hCAFE0018}) begin tests_failed++; $display("FAIL stall_hold[%0d]: got %b %b %b %b %h", i, BVALID, BRESP, RVALID, RRESP, RDATA); end
         tests_run++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin tests_failed++; $display("FAIL stall_ready[%0d]: got %b exp 000", i, {AWREADY, WREADY, ARREADY}); end
         tests_run++; if (ctrl_wr_pulse !== ((i == 0) ? 8'h08 : 8'h00)) begin tests_failed++; $display("FAIL stall_pulse[%0d]: got %h", i, ctrl_wr_pulse); end
         tick();
      end
      idle_bus();
      BREADY = 1'b1; RREADY = 1'b1;
      tick();
      BREADY = 1'b0; RREADY = 1'b0;
      tests_run++; if ({BVALID, RVALID} !== 2'b00) begin tests_failed++; $display("FAIL stall_release: got %b %b exp 0 0", BVALID, RVALID); end
      tests_run++; if ({ctrl_regs[96 +: 32], ctrl_regs[128 +: 32]} !== {exp_ctrl[3], exp_ctrl[4]}) begin tests_failed++; $display("FAIL stall_regs: got %h %h exp %h %h", ctrl_regs[96 +: 32], ctrl_regs[128 +: 32], exp_ctrl[3], exp_ctrl[4]); end
   endtask

   task automatic test_read_write_collision();
      AWADDR = 32'h00; WDATA = 32'h00000055; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h00; ARVALID = 1'b1;
      tick();
      idle_bus();
      exp_ctrl[0] = 32'h55;
      tests_run++; if (RDATA !== 32'h1) begin tests_failed++; $display("FAIL collide_rdata: got %h exp 00000001", RDATA); end
      tests_run++; if (ctrl_regs[0 +: 32] !== exp_ctrl[0]) begin tests_failed++; $display("FAIL collide_reg: got %h exp %h", ctrl_regs[0 +: 32], exp_ctrl[0]); end
      BREADY = 1'b1; RREADY = 1'b1;
      tick();
      BREADY = 1'b0; RREADY = 1'b0;
   endtask

   task automatic test_reset_mid();
      AWADDR = 32'h14; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      tests_run++; if (w_state_o !== 2'b01) begin tests_failed++; $display("FAIL mid_have_addr: got %b exp 01", w_state_o); end
      ARESET = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) exp_ctrl[k] = CTRL_DEF[k*32 +: 32];
      tests_run++; if ({w_state_o, ctrl_regs} !== {2'b00, CTRL_DEF}) begin tests_failed++; $display("FAIL mid_async_reset: got %b %h", w_state_o, ctrl_regs); end
      tick();
      ARESET = 1'b0;
      WDATA = 32'h77777777; WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      tests_run++; if ({BVALID, ctrl_regs[160 +: 32]} !== {1'b0, exp_ctrl[5]}) begin tests_failed++; $display("FAIL mid_no_write: got %b %h exp 0 %h", BVALID, ctrl_regs[160 +: 32], exp_ctrl[5]); end
      tests_run++; if ({w_state_o, AWREADY, WREADY} !== 4'b1010) begin tests_failed++; $display("FAIL mid_fresh_w: got %b %b %b exp 10 1 0", w_state_o, AWREADY, WREADY); end
   endtask

   initial begin
      test_reset();
      test_read_default();
      test_write_same_cycle();
      test_w_first_strobe();
      test_slverr();
      test_stall();
      test_read_write_collision();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
